branch_predictor: RTL and testbench

- Direction predictor and resolution checker for the 4-stage core.
- In FD it indexes a table of 2-bit saturating counters (optionally hashed with global history) and drives `jump` to the PC selector.
- In X it takes the resolved outcome of the branch plus the prediction piped down with it. It trains the table and drives the 3-bit `result` code back to the PC selector, which redirects on a mispredict.
- It also keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor_if.sv | 30 +++
 rtl/branch_predictor.sv | 104 ++++++++++
 tb/tb_branch_predictor.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Purpose: bundles the FD lookup, X resolution and statistics signals of the branch predictor.
// Latency: n/a (wires only).
// Backpressure: none; the core side keeps x_valid low on stalls and bubbles.
interface branch_predictor_if #(
   parameter int INDEX_BITS = 6
);
   logic [31:0]           fd_pc;
   logic                  fd_is_branch;
   logic                  jump;
   logic [INDEX_BITS-1:0] fd_index;
   logic                  x_valid;
   logic [INDEX_BITS-1:0] x_index;
   logic                  x_predict;
   logic                  x_taken;
   logic [2:0]            result;
   logic [31:0]           branch_count;
   logic [31:0]           mispredict_count;

   // Core pipeline side
   modport master (
      output fd_pc, fd_is_branch, x_valid, x_index, x_predict, x_taken,
      input  jump, fd_index, result, branch_count, mispredict_count
   );

   // Predictor side
   modport slave (
      input  fd_pc, fd_is_branch, x_valid, x_index, x_predict, x_taken,
      output jump, fd_index, result, branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_predictor.sv
// Purpose: 2-bit saturating-counter direction predictor with optional global history, resolution checker and stats.
// Latency: lookup and result are combinational (zero cycles); training/history/stats update on the next rising edge.
// Backpressure: none; each x_valid cycle trains exactly once, the lookup never stalls.
module branch_predictor #(
   parameter int         INDEX_BITS = 6,
   parameter int         GHR_BITS   = 0,
   parameter logic [1:0] INIT_CTR   = 2'b01
) (
   input logic             clk,
   input logic             rst,
   branch_predictor_if.slave bp
);
   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [1:0]            ctr_q [ENTRIES];
   logic [1:0]            ctr_d [ENTRIES];
   logic [31:0]           branch_count_q, branch_count_d;
   logic [31:0]           mispredict_count_q, mispredict_count_d;
   logic [INDEX_BITS-1:0] hist;
   logic [INDEX_BITS-1:0] fd_idx;
   logic                  mispredict;
   logic [2:0]            result;
   logic                  pc_unused;

   // Only the word-index slice of the PC feeds the table
   assign pc_unused = ^{bp.fd_pc[31:INDEX_BITS+2], bp.fd_pc[1:0]};

   generate
      if (GHR_BITS > 0) begin : g_ghr
         logic [GHR_BITS-1:0] ghr_q, ghr_d;

         // Shift in resolved outcomes only, so history is never speculative
         always_comb begin
            ghr_d = ghr_q;
            if (bp.x_valid) ghr_d = GHR_BITS'({ghr_q, bp.x_taken});
         end

         // History register
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) ghr_q <= '0;
            else      ghr_q <= ghr_d;
         end

         assign hist = INDEX_BITS'(ghr_q);
      end else begin : g_no_ghr
         assign hist = '0;
      end
   endgenerate

   assign fd_idx      = bp.fd_pc[INDEX_BITS+1:2] ^ hist;
   assign bp.fd_index = fd_idx;
   // Reads the registered table, so a same-cycle update at this index is not bypassed
   assign bp.jump     = bp.fd_is_branch & ctr_q[fd_idx][1];

   assign mispredict = bp.x_valid & (bp.x_predict != bp.x_taken);

   // Resolution code: ALU target on a missed taken, PC_X+4 on a wrong taken guess
   always_comb begin
      result = 3'b000;
      if (mispredict) result = bp.x_taken ? 3'b100 : 3'b110;
   end
   assign bp.result = result;

   // Train the one resolving entry with saturation at both ends
   always_comb begin
      ctr_d = ctr_q;
      if (bp.x_valid) begin
         if (bp.x_taken) begin
            if (ctr_q[bp.x_index] != 2'b11) ctr_d[bp.x_index] = ctr_q[bp.x_index] + 2'd1;
         end else begin
            if (ctr_q[bp.x_index] != 2'b00) ctr_d[bp.x_index] = ctr_q[bp.x_index] - 2'd1;
         end
      end
   end

   // Counter table
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_CTR;
      end else begin
         ctr_q <= ctr_d;
      end
   end

   // Statistics, wrapping modulo 2^32
   always_comb begin
      branch_count_d     = branch_count_q + {31'd0, bp.x_valid};
      mispredict_count_d = mispredict_count_q + {31'd0, mispredict};
   end

   // Statistics registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign bp.branch_count     = branch_count_q;
   assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Purpose: self-checking bench for branch_predictor, bimodal and 2-bit-history instances side by side.
// Latency: checks combinational outputs 1 time unit after each negedge drive.
// Backpressure: n/a.
module tb_branch_predictor;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   branch_predictor_if #(.INDEX_BITS(6)) bp0 ();
   branch_predictor_if #(.INDEX_BITS(6)) bp1 ();

   branch_predictor #(.INDEX_BITS(6), .GHR_BITS(0), .INIT_CTR(2'b01)) u_dut0 (
      .clk(clk), .rst(rst), .bp(bp0)
   );
   branch_predictor #(.INDEX_BITS(6), .GHR_BITS(2), .INIT_CTR(2'b01)) u_dut1 (
      .clk(clk), .rst(rst), .bp(bp1)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: counter values as plain integers, history as an integer
   int          mctr [2][64];
   int          mghr [2];
   int          gbits [2] = '{0, 2};
   logic [31:0] mbc, mmc;

   logic [31:0] cur_pc;
   logic        cur_isb, cur_xv, cur_xp, cur_xt;
   logic [5:0]  cur_xi;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 64; i++) mctr[d][i] = 1;
         mghr[d] = 0;
      end
      mbc = 32'd0;
      mmc = 32'd0;
   endtask

   function automatic int m_index(input int d);
      logic [31:0] v;
      v = (cur_pc >> 2) ^ 32'(mghr[d]);
      return int'(v & 32'd63);
   endfunction

   function automatic logic [2:0] m_result();
      if (!cur_xv)             return 3'd0;
      if (cur_xt && !cur_xp)   return 3'b100;
      if (!cur_xt && cur_xp)   return 3'b110;
      return 3'd0;
   endfunction

   task automatic model_clock();
      if (cur_xv) begin
         for (int d = 0; d < 2; d++) begin
            if (cur_xt) mctr[d][cur_xi] = (mctr[d][cur_xi] == 3) ? 3 : mctr[d][cur_xi] + 1;
            else        mctr[d][cur_xi] = (mctr[d][cur_xi] == 0) ? 0 : mctr[d][cur_xi] - 1;
            mghr[d] = ((mghr[d] << 1) | int'(cur_xt)) & ((1 << gbits[d]) - 1);
         end
         mbc = mbc + 32'd1;
         if (cur_xp != cur_xt) mmc = mmc + 32'd1;
      end
   endtask

   task automatic check_all();
      logic        jo [2];
      logic [5:0]  io [2];
      logic [2:0]  ro [2];
      logic [31:0] bo [2];
      logic [31:0] mo [2];
      int          idx;
      jo[0] = bp0.jump;     jo[1] = bp1.jump;
      io[0] = bp0.fd_index; io[1] = bp1.fd_index;
      ro[0] = bp0.result;   ro[1] = bp1.result;
      bo[0] = bp0.branch_count;     bo[1] = bp1.branch_count;
      mo[0] = bp0.mispredict_count; mo[1] = bp1.mispredict_count;
      for (int d = 0; d < 2; d++) begin
         idx = m_index(d);
         check($sformatf("fd_index%0d", d), 32'(io[d]), 32'(idx));
         check($sformatf("jump%0d", d), 32'(jo[d]), 32'(cur_isb && (mctr[d][idx] >= 2)));
         check($sformatf("result%0d", d), 32'(ro[d]), 32'(m_result()));
         check($sformatf("branch_count%0d", d), bo[d], mbc);
         check($sformatf("mispredict_count%0d", d), mo[d], mmc);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic isb, input logic xv,
                        input logic [5:0] xi, input logic xp, input logic xt);
      cur_pc = pc; cur_isb = isb; cur_xv = xv; cur_xi = xi; cur_xp = xp; cur_xt = xt;
      bp0.fd_pc = pc; bp0.fd_is_branch = isb; bp0.x_valid = xv;
      bp0.x_index = xi; bp0.x_predict = xp; bp0.x_taken = xt;
      bp1.fd_pc = pc; bp1.fd_is_branch = isb; bp1.x_valid = xv;
      bp1.x_index = xi; bp1.x_predict = xp; bp1.x_taken = xt;
   endtask

   task automatic drive_check(input logic [31:0] pc, input logic isb, input logic xv,
                              input logic [5:0] xi, input logic xp, input logic xt);
      drive(pc, isb, xv, xi, xp, xt);
      #1;
      check_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   initial begin
      drive(32'h0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Post-reset lookup
      drive_check(32'h100, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      check("t1_jump", 32'(bp0.jump), 32'd0);
      check("t1_index", 32'(bp0.fd_index), 32'h00);
      check("t1_result", 32'(bp0.result), 32'd0);
      tick();

      // History: two taken resolves give ghr=11, index of 0x100 becomes 3
      drive_check(32'h0, 1'b0, 1'b1, 6'h20, 1'b0, 1'b1); tick();
      drive_check(32'h0, 1'b0, 1'b1, 6'h20, 1'b0, 1'b1); tick();
      drive_check(32'h100, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      check("t5_ghr_index", 32'(bp1.fd_index), 32'h03);
      check("t5_bimodal_index", 32'(bp0.fd_index), 32'h00);
      tick();

      // Bimodal training on index 5 with same-cycle hazard on the first update
      drive_check(32'h14, 1'b1, 1'b1, 6'd5, 1'b1, 1'b1);
      check("t4_hazard_jump", 32'(bp0.jump), 32'd0);
      tick();
      drive_check(32'h14, 1'b1, 1'b1, 6'd5, 1'b1, 1'b1);
      check("t4_next_jump", 32'(bp0.jump), 32'd1);
      tick();
      drive_check(32'h14, 1'b1, 1'b1, 6'd5, 1'b1, 1'b1); tick();
      drive_check(32'h14, 1'b1, 1'b0, 6'd5, 1'b0, 1'b0);
      check("t2_sat_jump", 32'(bp0.jump), 32'd1);
      tick();
      drive_check(32'h14, 1'b0, 1'b0, 6'd5, 1'b0, 1'b0);
      check("t5_not_branch", 32'(bp0.jump), 32'd0);
      tick();
      drive_check(32'h14, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0); tick();
      drive_check(32'h14, 1'b1, 1'b1, 6'd5, 1'b1, 1'b0); tick();
      drive_check(32'h14, 1'b1, 1'b0, 6'd5, 1'b0, 1'b0);
      check("t2_untrained_jump", 32'(bp0.jump), 32'd0);
      tick();

      // Result codes
      drive_check(32'h0, 1'b0, 1'b1, 6'd9, 1'b0, 1'b1);
      check("t3_code_100", 32'(bp0.result), 32'b100);
      tick();
      drive_check(32'h0, 1'b0, 1'b1, 6'd9, 1'b1, 1'b0);
      check("t3_code_110", 32'(bp0.result), 32'b110);
      tick();
      drive_check(32'h0, 1'b0, 1'b1, 6'd9, 1'b1, 1'b1);
      check("t3_code_ok", 32'(bp0.result), 32'b000);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive_check(32'h24, 1'b1, 1'b0, 6'd9, k[0], k[1]);
         check("t3_code_idle", 32'(bp0.result), 32'b000);
         tick();
      end

      // Asynchronous reset mid-run, held across an edge with x_valid high
      drive(32'h14, 1'b1, 1'b1, 6'd5, 1'b0, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      drive_check(32'h14, 1'b1, 1'b0, 6'd5, 1'b0, 1'b0);
      check("t1_reset_count", bp0.branch_count, 32'd0);
      tick();

      // Statistics wrap at 2^32
      force u_dut0.branch_count_q = 32'hFFFF_FFFF;
      force u_dut1.branch_count_q = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      release u_dut0.branch_count_q;
      release u_dut1.branch_count_q;
      mbc = 32'hFFFF_FFFF;
      drive_check(32'h0, 1'b0, 1'b1, 6'd3, 1'b1, 1'b1); tick();
      drive_check(32'h0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      check("t6_wrap", bp0.branch_count, 32'h0000_0000);
      check("t6_mis_kept", bp0.mispredict_count, 32'd0);
      tick();

      // Randomized traffic over a small index range so counters saturate and collide
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] pc;
         pc = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
              | ($urandom & 32'hFFFF_0000);
         drive_check(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                     6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
